// File: rtl/swerv_trace_event_sched_if.sv
// Signal bundle between the pipeline trace taps, the trace sink and the event scheduler.
// The ev_time field exists only when SWERV_TRACE_TIMESTAMP_EN is defined.
interface swerv_trace_event_sched_if #(
    parameter int CNT_W = 16
);
    logic [13:0]      src_valid;
    logic [14*32-1:0] src_pc;
    logic [31:0]      dec_insn0;
    logic [31:0]      dec_insn1;
    logic             ev_valid;
    logic             ev_ready;
    logic [3:0]       ev_src;
    logic [31:0]      ev_pc;
    logic [31:0]      ev_insn;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic             finish_req;
`ifdef SWERV_TRACE_TIMESTAMP_EN
    logic [31:0]      ev_time;
`endif

    // The scheduler is the master: it owns the event stream and the status flags.
    modport master (
        input  src_valid, src_pc, dec_insn0, dec_insn1, ev_ready,
`ifdef SWERV_TRACE_TIMESTAMP_EN
        output ev_time,
`endif
        output ev_valid, ev_src, ev_pc, ev_insn, overflow, drop_cnt, finish_req
    );

    modport slave (
        output src_valid, src_pc, dec_insn0, dec_insn1, ev_ready,
`ifdef SWERV_TRACE_TIMESTAMP_EN
        input  ev_time,
`endif
        input  ev_valid, ev_src, ev_pc, ev_insn, overflow, drop_cnt, finish_req
    );
endinterface

// File: rtl/swerv_trace_event_sched.sv
// Trace event scheduler: snapshots each cycle's stage events into a bundle FIFO and drains
// them one per cycle in source-index order. Optional capture timestamps: SWERV_TRACE_TIMESTAMP_EN.
module swerv_trace_event_sched #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input logic                       clk,
    input logic                       rst_l,
    swerv_trace_event_sched_if.master bus
);
    localparam int          NSRC        = 14;
    localparam int          AW          = $clog2(DEPTH);
    localparam logic [31:0] FINISH_INSN = 32'h0000_2013;
    localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NSRC-1:0]    mask_q  [DEPTH];
    logic [NSRC*32-1:0] pc_q    [DEPTH];
    logic [31:0]        insn0_q [DEPTH];
    logic [31:0]        insn1_q [DEPTH];

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_idx, rd_idx;
    logic               fifo_empty, fifo_full;

    logic [NSRC-1:0]    head_mask, sel_onehot, remain;
    logic [NSRC*32-1:0] head_pc;
    logic [3:0]         sel_src;
    logic               handshake, pop, push_req, push_ok, drop;

    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic [1:0]         arm_q, arm_d;
    logic               pending_q, pending_d;
    logic               finish_req_q, finish_req_d;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign head_mask  = mask_q[rd_idx];
    assign head_pc    = pc_q[rd_idx];
    assign sel_onehot = head_mask & (~head_mask + {{(NSRC-1){1'b0}}, 1'b1});
    assign remain     = head_mask & ~sel_onehot;

    always_comb begin
        sel_src = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (head_mask[i]) sel_src = 4'(i);
        end
    end

    // A full FIFO still takes a new bundle when the head retires its last event this cycle.
    assign handshake = !fifo_empty && bus.ev_ready;
    assign pop       = handshake && (remain == '0);
    assign push_req  = |bus.src_valid;
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && !push_ok;

    always_comb begin
        wr_ptr_d     = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        drop_cnt_d   = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_ONE : drop_cnt_q;
        overflow_d   = overflow_q | drop;
        pending_d    = pending_q | (|(bus.src_valid[1:0] & arm_q));
        finish_req_d = finish_req_q | (pending_q & fifo_empty);
        arm_d        = arm_q & ~bus.src_valid[1:0];
        if (bus.src_valid[10] && (bus.dec_insn0 == FINISH_INSN)) arm_d[0] = 1'b1;
        if (bus.src_valid[11] && (bus.dec_insn1 == FINISH_INSN)) arm_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            arm_q        <= '0;
            pending_q    <= 1'b0;
            finish_req_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            arm_q        <= arm_d;
            pending_q    <= pending_d;
            finish_req_q <= finish_req_d;
        end
    end

    // Head and write slots only coincide when full or empty, so the two writes never collide.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) mask_q[i] <= '0;
        end else begin
            if (handshake && !pop) mask_q[rd_idx] <= remain;
            if (push_ok)           mask_q[wr_idx] <= bus.src_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_q[wr_idx]    <= bus.src_pc;
            insn0_q[wr_idx] <= bus.dec_insn0;
            insn1_q[wr_idx] <= bus.dec_insn1;
        end
    end

    assign bus.ev_valid   = !fifo_empty;
    assign bus.ev_src     = sel_src;
    assign bus.ev_pc      = head_pc[{sel_src, 5'd0} +: 32];
    assign bus.ev_insn    = (sel_src == 4'd10) ? insn0_q[rd_idx] :
                            (sel_src == 4'd11) ? insn1_q[rd_idx] : 32'h0;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.finish_req = finish_req_q | (pending_q & fifo_empty);

`ifdef SWERV_TRACE_TIMESTAMP_EN
    logic [31:0] time_q;
    logic [31:0] stamp_q [DEPTH];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) time_q <= '0;
        else        time_q <= time_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) stamp_q[wr_idx] <= time_q;
    end

    assign bus.ev_time = stamp_q[rd_idx];
`endif
endmodule
